// File: rtl/async_req_arbiter.sv
// async_req_arbiter
//   Arbitrates a shared resource between NREQ requesters that signal
//   asynchronously. Each request level is synchronized and edge-detected
//   into a pending bit. A three-state FSM (IDLE, GRANT, RELEASE) hands out
//   one registered one-hot grant at a time. The grant is released by done
//   or, after HOLD_MAX cycles, by a forced timeout.
//
//   Build option: define ROUND_ROBIN_EN for round-robin selection. The
//   search starts at the index after the last granted requester. Without
//   the macro, the lowest pending index always wins.
//
//   Handshake: a requester raises async_req to ask for service. Each rising
//   edge counts as one request. The resource owner sees its grant bit and
//   pulses done for one cycle to hand the resource back. done is looked at
//   only while busy is high.
//
//   Ports
//     clk        clock, rising edge
//     n_rst      asynchronous active-low reset
//     async_req  [NREQ]  asynchronous request levels
//     done       synchronous release from the resource
//     grant      [NREQ]  registered one-hot grant, zero when none is held
//     grant_id   index of the current or last granted requester
//     busy       high while the FSM is in GRANT
//     timeout    one-cycle pulse on the cycle a forced release is taken
//     state_dbg  current FSM state (0 IDLE, 1 GRANT, 2 RELEASE)
module async_req_arbiter #(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 15
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NREQ-1:0]         async_req,
   input  logic                    done,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    timeout,
   output logic [1:0]              state_dbg
);

   localparam int IDW = $clog2(NREQ);
   localparam logic [7:0] HOLD_MAX_W = 8'(HOLD_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [NREQ-1:0]   sync1, sync2, sync3;
   logic              started;
   logic [NREQ-1:0]   armed;
   logic [NREQ-1:0]   rise;
   logic [NREQ-1:0]   pending, pending_nxt, clr;
   logic [NREQ-1:0]   grant_nxt, sel_onehot;
   logic [IDW-1:0]    grant_id_nxt, sel_idx;
   logic [7:0]        hold_cnt, hold_nxt;

   // Synchronizer, edge-detect copy and arming.
   // A requester is armed only after its synchronized level has been seen
   // low after reset. A level already high when reset is released
   // therefore gives no request until it falls and rises again.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1   <= '0;
         sync2   <= '0;
         sync3   <= '0;
         started <= 1'b0;
         armed   <= '0;
      end else begin
         sync1   <= async_req;
         sync2   <= sync1;
         sync3   <= sync2;
         started <= 1'b1;
         if (started)
            armed <= armed | ~sync1;
      end
   end

   assign rise = sync2 & ~sync3 & armed;

`ifdef ROUND_ROBIN_EN
   localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

   logic [IDW-1:0]    rr_ptr, rr_off;
   logic [2*NREQ-1:0] rot2;
   logic [IDW:0]      rr_sum;

   // Rotate pending so that rr_ptr sits at bit 0. Take the lowest set bit,
   // then rotate the offset back into an absolute index.
   always_comb begin
      rot2   = {pending, pending} >> rr_ptr;
      rr_off = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot2[i]) rr_off = IDW'(i);
      rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
      if (rr_sum >= NREQ_W)
         rr_sum = rr_sum - NREQ_W;
      sel_idx = rr_sum[IDW-1:0];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         rr_ptr <= '0;
      else if (state == IDLE && (|pending))
         rr_ptr <= (sel_idx == LAST_ID) ? '0 : sel_idx + 1'b1;
   end
`else
   always_comb begin
      sel_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (pending[i]) sel_idx = IDW'(i);
   end
`endif

   assign sel_onehot = NREQ'(1) << sel_idx;

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      hold_nxt     = hold_cnt;
      clr          = '0;
      timeout      = 1'b0;
      case (state)
         IDLE: begin
            if (|pending) begin
               state_nxt    = GRANT;
               grant_nxt    = sel_onehot;
               grant_id_nxt = sel_idx;
               clr          = sel_onehot;
               hold_nxt     = 8'd1;
            end
         end
         GRANT: begin
            hold_nxt = hold_cnt + 8'd1;
            // done has priority over the forced release on the last cycle.
            if (done) begin
               state_nxt = RELEASE;
               grant_nxt = '0;
            end else if (hold_cnt == HOLD_MAX_W) begin
               state_nxt = RELEASE;
               grant_nxt = '0;
               timeout   = 1'b1;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            hold_nxt  = '0;
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
      // A new edge in the same cycle as the clear keeps the bit set.
      pending_nxt = (pending & ~clr) | rise;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         hold_cnt <= '0;
         pending  <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         grant_id <= grant_id_nxt;
         hold_cnt <= hold_nxt;
         pending  <= pending_nxt;
      end
   end

   assign busy      = (state == GRANT);
   assign state_dbg = state;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed bench for async_req_arbiter (NREQ=4, HOLD_MAX=15).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_async_req_arbiter;
   localparam int NREQ     = 4;
   localparam int HOLD_MAX = 15;

   logic            clk = 1'b0;
   logic            n_rst;
   logic [NREQ-1:0] async_req;
   logic            done;
   logic [NREQ-1:0] grant;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout;
   logic [1:0]      state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [NREQ-1:0] exp_q[$];
   bit              rereq_q[$];

   always #5 clk = ~clk;

   async_req_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .async_req (async_req),
      .done      (done),
      .grant     (grant),
      .grant_id  (grant_id),
      .busy      (busy),
      .timeout   (timeout),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bounded wait for any grant. Returns the number of cycles waited.
   task automatic wait_grant(output int cycles);
      cycles = 0;
      while (grant == '0 && cycles < 30) begin
         step(1);
         cycles++;
      end
   endtask

   // Serve one grant: check who got it and how long it took, optionally
   // re-toggle requester 0, then release with done and check the gap.
   task automatic serve(input logic [NREQ-1:0] exp_grant, input bit rereq0,
                        input int exp_wait, input string tag);
      int cyc;
      wait_grant(cyc);
      check({tag, "_grant"}, grant, exp_grant);
      check({tag, "_wait"}, cyc, exp_wait);
      if (rereq0) begin
         async_req[0] = 1'b0;
         step(2);
         async_req[0] = 1'b1;
      end
      step(4);
      done = 1'b1;
      step(1);
      done = 1'b0;
      check({tag, "_release"}, grant, 0);
      check({tag, "_rel_busy"}, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   cyc;
      logic early;
      int   n;
      n_rst     = 1'b1;
      async_req = '0;
      done      = 1'b0;
      #1 n_rst  = 1'b0;
      #1;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_state", state_dbg, 0);
      step(2);
      n_rst = 1'b1;
      step(3);

      // Single request on requester 2 and the done handshake.
      async_req[2] = 1'b1;
      step(3);
      check("lat_early", grant, 0);
      step(1);
      check("single_grant", grant, 4'b0100);
      check("single_id", grant_id, 2);
      check("single_busy", busy, 1);
      check("single_to", timeout, 0);
      done = 1'b1;
      step(1);
      done = 1'b0;
      check("rel_grant", grant, 0);
      check("rel_busy", busy, 0);
      check("rel_state", state_dbg, 2);
      step(1);
      check("idle_state", state_dbg, 0);
      // done outside GRANT and a held-high level produce nothing more.
      done = 1'b1;
      step(2);
      done = 1'b0;
      step(6);
      check("held_once", grant, 0);
      check("held_busy", busy, 0);
      async_req[2] = 1'b0;
      step(2);

      // Forced release on requester 1.
      async_req[1] = 1'b1;
      wait_grant(cyc);
      check("to_grant", grant, 4'b0010);
      check("to_wait", cyc, 4);
      early = 1'b0;
      for (int c = 2; c <= HOLD_MAX - 1; c++) begin
         step(1);
         early = early | timeout;
      end
      check("to_early", early, 0);
      step(1);
      check("to_pulse", timeout, 1);
      check("to_busy", busy, 1);
      check("to_grant_last", grant, 4'b0010);
      step(1);
      check("to_after_grant", grant, 0);
      check("to_after_pulse", timeout, 0);
      check("to_after_busy", busy, 0);

      // done on the HOLD_MAX cycle wins over the timeout.
      async_req[3] = 1'b1;
      wait_grant(cyc);
      check("bnd_grant", grant, 4'b1000);
      step(HOLD_MAX - 1);
      check("bnd_to_without_done", timeout, 1);
      done = 1'b1;
      #1;
      check("bnd_to_with_done", timeout, 0);
      step(1);
      check("bnd_rel_grant", grant, 0);
      check("bnd_rel_to", timeout, 0);
      check("bnd_rel_state", state_dbg, 2);
      done = 1'b0;
      async_req = '0;
      step(4);

      // Contention between requesters 0, 1 and 3.
`ifdef ROUND_ROBIN_EN
      exp_q   = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      rereq_q = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
      exp_q   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000};
      rereq_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
      async_req = 4'b1011;
      n = 0;
      while (exp_q.size() > 0) begin
         serve(exp_q.pop_front(), rereq_q.pop_front(), (n == 0) ? 4 : 2,
               $sformatf("cont%0d", n));
         n++;
      end
      step(4);
      check("cont_no_extra", grant, 0);
      async_req = '0;
      step(4);

      // Reset in the middle of a grant. Requester 3 is held through reset.
      async_req = 4'b1100;
      wait_grant(cyc);
      check("rg_grant", grant, 4'b0100);
      check("rg_id", grant_id, 2);
      step(2);
      #2 n_rst = 1'b0;
      #1;
      check("rg_async_grant", grant, 0);
      check("rg_async_busy", busy, 0);
      check("rg_async_id", grant_id, 0);
      async_req[2] = 1'b0;
      step(2);
      n_rst = 1'b1;
      step(10);
      check("rg_held_no_grant", grant, 0);
      async_req[3] = 1'b0;
      step(3);
      async_req[3] = 1'b1;
      wait_grant(cyc);
      check("rg_regrant", grant, 4'b1000);
      check("rg_regrant_wait", cyc, 4);
      done = 1'b1;
      step(1);
      done = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
